wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Write-back stage plus architectural register file, directly downstream of the MEM/WB register.
//  Selects write address/data from the registered MEM/WB fields and commits them to a 32x32 file.
//  Serves the two ID-stage read ports with same-cycle write-through bypass and exposes a retire counter.
// PARAMETERS
//  DATA_W   32  register and data width
//  NREG     32  register count; index 0 hardwired to zero
//  LINK_REG 31  destination index for Jal
//  LINK_OFS 4   added to wb_pc to form the Jal link value
// PORTS
//  clk          in   1   rising-edge clock, single domain
//  reset        in   1   synchronous, active-low reset
//  wb_RegWrite  in   1   commit enable from MEM/WB
//  wb_Jal       in   1   link write: addr=LINK_REG, data=wb_pc+LINK_OFS
//  wb_RegDST    in   1   1: dest=rd_addr, 0: dest=rt_addr
//  wb_MemtoReg  in   1   1: data=ReadData, 0: data=ALUResult
//  wb_ReadData  in   32  load data
//  wb_ALUResult in   32  ALU result
//  wb_rt_addr   in   5   rt field
//  wb_rd_addr   in   5   rd field
//  wb_pc        in   32  PC of the retiring instruction
//  rs_addr      in   5   read port A index (ID stage)
//  rt_addr      in   5   read port B index (ID stage)
//  rs_data      out  32  read port A data
//  rt_data      out  32  read port B data
//  wr_en        out  1   registered: a non-zero write committed last edge
//  wr_addr      out  5   registered: index of last commit
//  wr_data      out  32  registered: value of last commit
//  retire_cnt   out  32  registered count of committed writes
// BEHAVIOUR
//  Reset: on posedge clk with reset==0, all NREG entries <= 0, wr_en<=0, wr_addr<=0, wr_data<=0, retire_cnt<=0.
//   Reset wins over any concurrent write; a write presented in the reset cycle is dropped.
//  Dest select (comb): Jal ? LINK_REG : (RegDST ? rd_addr : rt_addr). Jal overrides RegDST.
//  Data select (comb): Jal ? wb_pc+LINK_OFS (mod 2^32) : (MemtoReg ? ReadData : ALUResult). Jal overrides MemtoReg.
//  Commit: eff_we = wb_RegWrite & (dest != 0). On posedge, if eff_we, regs[dest] <= data; latency 1 edge.
//   Writes to index 0 are discarded; regs[0] reads 0 always, never counted.
//  Read ports (comb, 0-cycle): idx==0 -> 0; else if eff_we && idx==dest -> selected write data (bypass);
//   else regs[idx]. Both ports independent; both may bypass in the same cycle.
//  Status: on posedge, wr_en<=eff_we; when eff_we, wr_addr<=dest, wr_data<=data (else hold).
//  retire_cnt: +1 per eff_we edge; wraps 0xFFFF_FFFF -> 0 with no flag.
//  No stall/flush inputs: a bubble upstream is wb_RegWrite==0 and is a no-op.
//  X on wb_* data with wb_RegWrite==0 must not propagate to any state.
// TESTING
//  Reset: hold reset=0 two edges after random writes -> all reads 0, retire_cnt=0, wr_en=0.
//  R-type: RegWrite=1,RegDST=1,rd=5,ALUResult=0x1234 -> same cycle rs_addr=5 reads 0x1234; after edge regs[5]=0x1234, retire_cnt=1.
//  Load: RegWrite=1,MemtoReg=1,RegDST=0,rt=7,ReadData=0xDEADBEEF,ALUResult=0x1 -> regs[7]=0xDEADBEEF.
//  Jal: Jal=1,RegDST=1,rd=3,wb_pc=0x0040_0010 -> regs[31]=0x0040_0014, regs[3] unchanged.
//  $zero: RegWrite=1,RegDST=1,rd=0,ALUResult=0xFFFF -> rs_addr=0 reads 0, wr_en=0, retire_cnt unchanged.
//  Reset vs write: reset=0 with RegWrite=1,rd=9 same cycle -> regs[9]=0; preload retire_cnt to 0xFFFFFFFF via writes/force, one write -> 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select plus 32x32 architectural register file with
// write-through read bypass, last-commit status and retire counter.
`default_nettype none

module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int LINK_REG = 31,
  parameter int LINK_OFS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_RegWrite,
  input  logic              wb_Jal,
  input  logic              wb_RegDST,
  input  logic              wb_MemtoReg,
  input  logic [DATA_W-1:0] wb_ReadData,
  input  logic [DATA_W-1:0] wb_ALUResult,
  input  logic [4:0]        wb_rt_addr,
  input  logic [4:0]        wb_rd_addr,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       retire_cnt
);

  logic [DATA_W-1:0] regs [NREG];
  logic [4:0]        dest;
  logic [DATA_W-1:0] data;
  logic              eff_we;

  always_comb begin
    dest = wb_Jal ? 5'(LINK_REG) : (wb_RegDST ? wb_rd_addr : wb_rt_addr);
    if (wb_Jal)
      data = wb_pc + DATA_W'(LINK_OFS);
    else
      data = wb_MemtoReg ? wb_ReadData : wb_ALUResult;
    eff_we = wb_RegWrite & (dest != 5'd0);
  end

  // Bypass lets ID see a value committing at this very edge.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != 5'd0)
      rs_data = (eff_we && rs_addr == dest) ? data : regs[rs_addr];
    if (rt_addr != 5'd0)
      rt_data = (eff_we && rt_addr == dest) ? data : regs[rt_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      retire_cnt <= '0;
    end else begin
      wr_en <= eff_we;
      if (eff_we) begin
        regs[dest] <= data;
        wr_addr    <= dest;
        wr_data    <= data;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire
